reg_if_timeout_guard: RTL and testbench
=======================================

# reg_if_timeout_guard

Pipeline stage on the simple register interface, between `axi_lite_slave`'s register port (upstream) and a user register block (downstream). It re-issues each write or read downstream as a single-cycle request and waits for the completion strobe. If the downstream block never answers, the guard completes the transaction itself with an error, so the AXI-Lite bus cannot hang. It also counts timeouts for debug.

## Interface
- ADDR_WIDTH, 32, register address width
- DATA_WIDTH, 32, register data width
- TIMEOUT, 256, cycles to wait for a downstream strobe; must be ≥2
- TIMEOUT_DATA, 32'hDEADC0DE, read data returned on timeout; truncated or zero-extended to DATA_WIDTH
- COUNT_WIDTH, 16, width of the timeout counter
- i_axi_clk  in  1  sole clock
- i_axi_rst  in  1  reset, asynchronous, active-low
- i_up_reg_address  in  ADDR_WIDTH  address from upstream
- o_up_reg_invalid_addr  out  1  error flag, valid with the ack/rdy strobe
- i_up_reg_in_rdy  in  1  write pending (level)
- o_up_reg_in_ack_stb  out  1  write complete, 1-cycle pulse
- i_up_reg_in_data  in  DATA_WIDTH  write data
- i_up_reg_out_req  in  1  read pending (level)
- o_up_reg_out_rdy_stb  out  1  read complete, 1-cycle pulse
- o_up_reg_out_data  out  DATA_WIDTH  read data, valid with rdy_stb and held afterwards
- o_dn_reg_address  out  ADDR_WIDTH  registered address to downstream
- i_dn_reg_invalid_addr  in  1  downstream error flag, sampled with its strobe
- o_dn_reg_in_rdy  out  1  write request, 1-cycle pulse
- i_dn_reg_in_ack_stb  in  1  downstream write done
- o_dn_reg_in_data  out  DATA_WIDTH  registered write data
- o_dn_reg_out_req  out  1  read request, 1-cycle pulse
- i_dn_reg_out_rdy_stb  in  1  downstream read done
- i_dn_reg_out_data  in  DATA_WIDTH  downstream read data, sampled with rdy_stb
- o_timeout_stb  out  1  1-cycle pulse per timeout
- o_timeout_count  out  COUNT_WIDTH  saturating count of timeouts

## Operation
- States: IDLE, WR_WAIT, RD_WAIT, HOLD.
- IDLE:
  - If i_up_reg_in_rdy is high: register address and data to the dn outputs, pulse o_dn_reg_in_rdy, go to WR_WAIT, clear the wait counter.
  - Otherwise, if i_up_reg_out_req is high: register the address, pulse o_dn_reg_out_req, go to RD_WAIT.
  - Write takes priority when both are high.
- WR_WAIT:
  - On i_dn_reg_in_ack_stb: pulse o_up_reg_in_ack_stb, set o_up_reg_invalid_addr to i_dn_reg_invalid_addr, go to HOLD.
  - Otherwise increment the wait counter. When it reaches TIMEOUT with no strobe: pulse ack with invalid_addr=1, pulse o_timeout_stb, increment o_timeout_count (saturating at all-ones), go to HOLD.
- RD_WAIT: same as WR_WAIT, using i_dn_reg_out_rdy_stb.
  - Normal completion: o_up_reg_out_data ← i_dn_reg_out_data.
  - Timeout: o_up_reg_out_data ← TIMEOUT_DATA, invalid_addr=1.
- HOLD: stay until i_up_reg_in_rdy=0 and i_up_reg_out_req=0, then go to IDLE. This prevents a second issue of the same transaction.
- Downstream strobes that arrive in IDLE or HOLD (late responses) are ignored and have no effect.
- A strobe in the same cycle the counter expires counts as normal completion: no timeout is counted.
- o_dn_reg_address and o_dn_reg_in_data stay stable from issue until the next issue.
- o_up_reg_invalid_addr is 0 except in the cycle of an up strobe.

## Timing
- Every output is registered. In reset, all outputs are 0, state is IDLE and the counters are 0.
- Reset asserted mid-transaction abandons the transaction: no strobe is emitted, and IDLE follows deassertion.
- Upstream request seen in cycle N → downstream pulse in cycle N+1.
- Downstream strobe in cycle M → upstream strobe in cycle M+1.
- Round trip = downstream latency + 2 cycles.
- Timeout: the upstream strobe occurs in cycle N+1+TIMEOUT when no downstream strobe arrives in cycles N+1..N+TIMEOUT.
- The upstream completion strobe is exactly 1 cycle wide. o_timeout_stb coincides with it.
- The minimum spacing between issues is 1 cycle of HOLD after the upstream level drops.

## Test plan
- Write addr 0x0, data 0x12345678, downstream acks 1 cycle after the rdy pulse → o_dn_reg_in_data=0x12345678 with a 1-cycle rdy; up ack 1 cycle after dn ack; invalid_addr=0; no timeout.
- Read addr 0x4, downstream returns 0x10000000 with rdy_stb 1 cycle after the req pulse → o_up_reg_out_data=0x10000000 with rdy_stb; invalid_addr=0.
- Read with a silent downstream, TIMEOUT=8 → rdy_stb 9 cycles after issue, data=0xDEADC0DE, invalid_addr=1, o_timeout_stb pulse, o_timeout_count=1. A dn strobe injected afterwards is ignored.
- Write and read requests high together → write issued first; the read is issued only after HOLD clears and the read request is re-presented.
- Upstream rdy held high for 5 cycles after ack → exactly one dn pulse and one up ack. Downstream ack arriving on the expiry cycle → normal completion, count unchanged.
- Reset asserted during WR_WAIT → all outputs 0 immediately; no ack afterwards; o_timeout_count=0; a new write completes normally.

Source files
------------

// File: rtl/reg_if_timeout_guard.sv
// Register-interface guard stage: re-issues upstream reads/writes downstream as single-cycle
// requests and completes them with an error if the downstream block stays silent too long.
module reg_if_timeout_guard #(
  parameter int          ADDR_WIDTH   = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter int          TIMEOUT      = 256,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADC0DE,
  parameter int          COUNT_WIDTH  = 16
) (
  input  logic                   i_axi_clk,
  input  logic                   i_axi_rst,
  input  logic [ADDR_WIDTH-1:0]  i_up_reg_address,
  output logic                   o_up_reg_invalid_addr,
  input  logic                   i_up_reg_in_rdy,
  output logic                   o_up_reg_in_ack_stb,
  input  logic [DATA_WIDTH-1:0]  i_up_reg_in_data,
  input  logic                   i_up_reg_out_req,
  output logic                   o_up_reg_out_rdy_stb,
  output logic [DATA_WIDTH-1:0]  o_up_reg_out_data,
  output logic [ADDR_WIDTH-1:0]  o_dn_reg_address,
  input  logic                   i_dn_reg_invalid_addr,
  output logic                   o_dn_reg_in_rdy,
  input  logic                   i_dn_reg_in_ack_stb,
  output logic [DATA_WIDTH-1:0]  o_dn_reg_in_data,
  output logic                   o_dn_reg_out_req,
  input  logic                   i_dn_reg_out_rdy_stb,
  input  logic [DATA_WIDTH-1:0]  i_dn_reg_out_data,
  output logic                   o_timeout_stb,
  output logic [COUNT_WIDTH-1:0] o_timeout_count
);

  // state     | meaning
  // S_IDLE    | waiting for an upstream read or write level
  // S_WR_WAIT | write issued downstream, waiting for ack or timeout
  // S_RD_WAIT | read issued downstream, waiting for rdy or timeout
  // S_HOLD    | completed, waiting for upstream levels to drop

  localparam int                    WAIT_W    = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] TO_DATA   = DATA_WIDTH'(TIMEOUT_DATA);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_WAIT = 2'd1,
    S_RD_WAIT = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t                 r_state;
  logic [WAIT_W-1:0]      r_wait_cnt;
  logic [ADDR_WIDTH-1:0]  r_dn_address;
  logic [DATA_WIDTH-1:0]  r_dn_in_data;
  logic                   r_dn_in_rdy;
  logic                   r_dn_out_req;
  logic                   r_up_ack;
  logic                   r_up_rdy;
  logic                   r_up_invalid;
  logic [DATA_WIDTH-1:0]  r_up_out_data;
  logic                   r_timeout_stb;
  logic [COUNT_WIDTH-1:0] r_timeout_count;

  state_t                 w_state_nxt;
  logic [WAIT_W-1:0]      w_wait_cnt_nxt;
  logic [ADDR_WIDTH-1:0]  w_dn_address_nxt;
  logic [DATA_WIDTH-1:0]  w_dn_in_data_nxt;
  logic                   w_dn_in_rdy_nxt;
  logic                   w_dn_out_req_nxt;
  logic                   w_up_ack_nxt;
  logic                   w_up_rdy_nxt;
  logic                   w_up_invalid_nxt;
  logic [DATA_WIDTH-1:0]  w_up_out_data_nxt;
  logic                   w_timeout_stb_nxt;
  logic [COUNT_WIDTH-1:0] w_timeout_count_nxt;

  logic                   w_expired;
  logic [COUNT_WIDTH-1:0] w_count_sat;

  // Expiry is the last waiting cycle; a strobe in that same cycle still wins.
  assign w_expired   = (r_wait_cnt == WAIT_LAST);
  assign w_count_sat = (r_timeout_count == {COUNT_WIDTH{1'b1}}) ? r_timeout_count
                                                               : r_timeout_count + COUNT_WIDTH'(1);

  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    if (!i_axi_rst) begin
      r_state         <= S_IDLE;
      r_wait_cnt      <= '0;
      r_dn_address    <= '0;
      r_dn_in_data    <= '0;
      r_dn_in_rdy     <= 1'b0;
      r_dn_out_req    <= 1'b0;
      r_up_ack        <= 1'b0;
      r_up_rdy        <= 1'b0;
      r_up_invalid    <= 1'b0;
      r_up_out_data   <= '0;
      r_timeout_stb   <= 1'b0;
      r_timeout_count <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_wait_cnt      <= w_wait_cnt_nxt;
      r_dn_address    <= w_dn_address_nxt;
      r_dn_in_data    <= w_dn_in_data_nxt;
      r_dn_in_rdy     <= w_dn_in_rdy_nxt;
      r_dn_out_req    <= w_dn_out_req_nxt;
      r_up_ack        <= w_up_ack_nxt;
      r_up_rdy        <= w_up_rdy_nxt;
      r_up_invalid    <= w_up_invalid_nxt;
      r_up_out_data   <= w_up_out_data_nxt;
      r_timeout_stb   <= w_timeout_stb_nxt;
      r_timeout_count <= w_timeout_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_wait_cnt_nxt      = r_wait_cnt;
    w_dn_address_nxt    = r_dn_address;
    w_dn_in_data_nxt    = r_dn_in_data;
    w_dn_in_rdy_nxt     = 1'b0;
    w_dn_out_req_nxt    = 1'b0;
    w_up_ack_nxt        = 1'b0;
    w_up_rdy_nxt        = 1'b0;
    w_up_invalid_nxt    = 1'b0;
    w_up_out_data_nxt   = r_up_out_data;
    w_timeout_stb_nxt   = 1'b0;
    w_timeout_count_nxt = r_timeout_count;

    unique case (r_state)
      S_IDLE: begin
        if (i_up_reg_in_rdy) begin
          w_dn_address_nxt = i_up_reg_address;
          w_dn_in_data_nxt = i_up_reg_in_data;
          w_dn_in_rdy_nxt  = 1'b1;
          w_wait_cnt_nxt   = '0;
          w_state_nxt      = S_WR_WAIT;
        end else if (i_up_reg_out_req) begin
          w_dn_address_nxt = i_up_reg_address;
          w_dn_out_req_nxt = 1'b1;
          w_wait_cnt_nxt   = '0;
          w_state_nxt      = S_RD_WAIT;
        end
      end

      S_WR_WAIT: begin
        if (i_dn_reg_in_ack_stb) begin
          w_up_ack_nxt     = 1'b1;
          w_up_invalid_nxt = i_dn_reg_invalid_addr;
          w_state_nxt      = S_HOLD;
        end else if (w_expired) begin
          w_up_ack_nxt        = 1'b1;
          w_up_invalid_nxt    = 1'b1;
          w_timeout_stb_nxt   = 1'b1;
          w_timeout_count_nxt = w_count_sat;
          w_state_nxt         = S_HOLD;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end

      S_RD_WAIT: begin
        if (i_dn_reg_out_rdy_stb) begin
          w_up_rdy_nxt      = 1'b1;
          w_up_invalid_nxt  = i_dn_reg_invalid_addr;
          w_up_out_data_nxt = i_dn_reg_out_data;
          w_state_nxt       = S_HOLD;
        end else if (w_expired) begin
          w_up_rdy_nxt        = 1'b1;
          w_up_invalid_nxt    = 1'b1;
          w_up_out_data_nxt   = TO_DATA;
          w_timeout_stb_nxt   = 1'b1;
          w_timeout_count_nxt = w_count_sat;
          w_state_nxt         = S_HOLD;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end

      // Holding off until both levels drop keeps a still-high request from re-issuing.
      S_HOLD: begin
        if (!i_up_reg_in_rdy && !i_up_reg_out_req) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_up_reg_invalid_addr = r_up_invalid;
  assign o_up_reg_in_ack_stb   = r_up_ack;
  assign o_up_reg_out_rdy_stb  = r_up_rdy;
  assign o_up_reg_out_data     = r_up_out_data;
  assign o_dn_reg_address      = r_dn_address;
  assign o_dn_reg_in_rdy       = r_dn_in_rdy;
  assign o_dn_reg_in_data      = r_dn_in_data;
  assign o_dn_reg_out_req      = r_dn_out_req;
  assign o_timeout_stb         = r_timeout_stb;
  assign o_timeout_count       = r_timeout_count;

endmodule

// File: tb/tb_reg_if_timeout_guard.sv
// Directed bench for reg_if_timeout_guard: expected completions are queued at issue time
// and popped when the upstream strobe appears.
module tb_reg_if_timeout_guard;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] up_addr = '0;
  logic          up_rdy = 1'b0;
  logic [DW-1:0] up_wdata = '0;
  logic          up_req = 1'b0;
  logic          dn_inv = 1'b0;
  logic          dn_ack = 1'b0;
  logic          dn_rdy = 1'b0;
  logic [DW-1:0] dn_rdata = '0;

  logic          o_up_reg_invalid_addr;
  logic          o_up_reg_in_ack_stb;
  logic          o_up_reg_out_rdy_stb;
  logic [DW-1:0] o_up_reg_out_data;
  logic [AW-1:0] o_dn_reg_address;
  logic          o_dn_reg_in_rdy;
  logic [DW-1:0] o_dn_reg_in_data;
  logic          o_dn_reg_out_req;
  logic          o_timeout_stb;
  logic [CW-1:0] o_timeout_count;

  reg_if_timeout_guard #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO),
    .TIMEOUT_DATA(32'hDEADC0DE), .COUNT_WIDTH(CW)
  ) dut (
    .i_axi_clk(clk),
    .i_axi_rst(rst_n),
    .i_up_reg_address(up_addr),
    .o_up_reg_invalid_addr(o_up_reg_invalid_addr),
    .i_up_reg_in_rdy(up_rdy),
    .o_up_reg_in_ack_stb(o_up_reg_in_ack_stb),
    .i_up_reg_in_data(up_wdata),
    .i_up_reg_out_req(up_req),
    .o_up_reg_out_rdy_stb(o_up_reg_out_rdy_stb),
    .o_up_reg_out_data(o_up_reg_out_data),
    .o_dn_reg_address(o_dn_reg_address),
    .i_dn_reg_invalid_addr(dn_inv),
    .o_dn_reg_in_rdy(o_dn_reg_in_rdy),
    .i_dn_reg_in_ack_stb(dn_ack),
    .o_dn_reg_in_data(o_dn_reg_in_data),
    .o_dn_reg_out_req(o_dn_reg_out_req),
    .i_dn_reg_out_rdy_stb(dn_rdy),
    .i_dn_reg_out_data(dn_rdata),
    .o_timeout_stb(o_timeout_stb),
    .o_timeout_count(o_timeout_count)
  );

  always #5 clk = ~clk;

  int n_dn_wr = 0;
  int n_dn_rd = 0;
  int n_ack = 0;
  int n_rdy = 0;
  always @(negedge clk) begin
    if (o_dn_reg_in_rdy) n_dn_wr++;
    if (o_dn_reg_out_req) n_dn_rd++;
    if (o_up_reg_in_ack_stb) n_ack++;
    if (o_up_reg_out_rdy_stb) n_rdy++;
  end

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic          is_rd;
    logic          inv;
    logic [DW-1:0] data;
    logic          tmo;
    logic [CW-1:0] cnt;
    int            lat;
  } exp_t;
  exp_t exp_q[$];

  logic [DW-1:0] m_rdata = '0;
  logic [CW-1:0] m_cnt = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_up"}, {o_up_reg_invalid_addr, o_up_reg_in_ack_stb, o_up_reg_out_rdy_stb,
                       o_timeout_stb, o_timeout_count}, '0);
    chk({tag, "_rdata"}, o_up_reg_out_data, '0);
    chk({tag, "_dn_addr"}, o_dn_reg_address, '0);
    chk({tag, "_dn_wdata"}, o_dn_reg_in_data, '0);
    chk({tag, "_dn_pulses"}, {o_dn_reg_in_rdy, o_dn_reg_out_req}, '0);
  endtask

  // dn_lat: cycle (counted from the downstream pulse) in which the downstream strobe
  // is presented; 0 means the downstream stays silent.
  task automatic do_txn(input logic wr, input logic rd, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int dn_lat, input logic inv,
                        input logic [DW-1:0] rdata, input int hold);
    exp_t e;
    exp_t got_e;
    int   k;
    logic got;
    int   b_wr, b_rd, b_ack, b_rdy;
    b_wr = n_dn_wr; b_rd = n_dn_rd; b_ack = n_ack; b_rdy = n_rdy;

    e.is_rd = !wr;
    e.tmo   = (dn_lat == 0) || (dn_lat > TO - 1);
    e.inv   = e.tmo ? 1'b1 : inv;
    e.lat   = e.tmo ? TO : dn_lat + 1;
    if (e.tmo && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
    if (e.is_rd) m_rdata = e.tmo ? 32'hDEADC0DE : rdata;
    e.data = m_rdata;
    e.cnt  = m_cnt;
    exp_q.push_back(e);

    up_rdy = wr; up_req = rd; up_addr = addr; up_wdata = wdata;
    tick();
    chk("dn_wr_pulse", o_dn_reg_in_rdy, wr);
    chk("dn_rd_pulse", o_dn_reg_out_req, !wr);
    chk("dn_addr", o_dn_reg_address, addr);
    if (wr) chk("dn_wdata", o_dn_reg_in_data, wdata);

    got = 1'b0;
    k = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      tick();
      if (o_up_reg_in_ack_stb || o_up_reg_out_rdy_stb) begin
        got = 1'b1;
        k = c;
      end else begin
        dn_inv   = inv;
        dn_rdata = rdata;
        dn_ack   = wr && (c == dn_lat);
        dn_rdy   = !wr && (c == dn_lat);
      end
    end
    dn_ack = 1'b0; dn_rdy = 1'b0; dn_inv = 1'b0;
    chk("up_strobe_seen", got, 1'b1);

    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1'b1, 1'b0);
    end else begin
      got_e = exp_q.pop_front();
      chk("latency", k, got_e.lat);
      chk("up_ack", o_up_reg_in_ack_stb, !got_e.is_rd);
      chk("up_rdy", o_up_reg_out_rdy_stb, got_e.is_rd);
      chk("invalid", o_up_reg_invalid_addr, got_e.inv);
      chk("rdata", o_up_reg_out_data, got_e.data);
      chk("tmo_stb", o_timeout_stb, got_e.tmo);
      chk("tmo_cnt", o_timeout_count, got_e.cnt);
    end

    tick();
    chk("strobe_width", {o_up_reg_in_ack_stb, o_up_reg_out_rdy_stb, o_timeout_stb,
                         o_up_reg_invalid_addr}, 4'b0);
    repeat (hold) tick();
    up_rdy = 1'b0; up_req = 1'b0;
    tick();
    tick();
    chk("data_held", o_up_reg_out_data, m_rdata);
    chk("dn_addr_stable", o_dn_reg_address, addr);
    chk("dn_wr_count", n_dn_wr - b_wr, wr);
    chk("dn_rd_count", n_dn_rd - b_rd, !wr);
    chk("up_strobe_count", (n_ack - b_ack) + (n_rdy - b_rdy), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_up;
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    do_txn(1'b1, 1'b0, 32'h0, 32'h12345678, 1, 1'b0, '0, 0);
    do_txn(1'b0, 1'b1, 32'h4, '0, 1, 1'b0, 32'h10000000, 0);
    do_txn(1'b0, 1'b1, 32'h8, '0, 0, 1'b0, 32'h0BADBEEF, 0);

    // late downstream strobe while idle must be ignored
    b_up = n_ack + n_rdy;
    dn_rdy = 1'b1; dn_ack = 1'b1; dn_inv = 1'b1; dn_rdata = 32'h55555555;
    tick();
    dn_rdy = 1'b0; dn_ack = 1'b0; dn_inv = 1'b0;
    tick();
    tick();
    chk("late_no_strobe", (n_ack + n_rdy) - b_up, 0);
    chk("late_data_held", o_up_reg_out_data, 32'hDEADC0DE);
    chk("late_cnt", o_timeout_count, m_cnt);

    do_txn(1'b1, 1'b0, 32'h10, 32'hA5A5A5A5, 3, 1'b1, '0, 0);
    do_txn(1'b1, 1'b1, 32'h14, 32'h00C0FFEE, 2, 1'b0, 32'h11111111, 2);
    do_txn(1'b0, 1'b1, 32'h14, '0, 2, 1'b0, 32'h22222222, 0);
    do_txn(1'b1, 1'b0, 32'h18, 32'h33333333, 1, 1'b0, '0, 5);
    do_txn(1'b1, 1'b0, 32'h1C, 32'h44444444, TO - 1, 1'b0, '0, 0);
    do_txn(1'b1, 1'b0, 32'h20, 32'h66666666, 0, 1'b0, '0, 0);
    do_txn(1'b0, 1'b1, 32'h24, '0, TO, 1'b0, 32'h77777777, 0);
    do_txn(1'b1, 1'b0, 32'h28, 32'h88888888, 0, 1'b0, '0, 1);

    // reset in the middle of a write wait
    b_up = n_ack + n_rdy;
    up_rdy = 1'b1; up_addr = 32'h30; up_wdata = 32'hCAFEF00D;
    tick();
    chk("rst_txn_pulse", o_dn_reg_in_rdy, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    up_rdy = 1'b0;
    m_cnt = '0;
    m_rdata = '0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (TO + 4) tick();
    chk("rst_no_ack", (n_ack + n_rdy) - b_up, 0);
    chk("rst_cnt", o_timeout_count, '0);
    do_txn(1'b1, 1'b0, 32'h34, 32'h9ABCDEF0, 2, 1'b0, '0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
